// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline requests in, per-stage stall/flush and PC control out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  logic [NSTAGE-1:0] stall_req;
  logic [NSTAGE-1:0] flush_req;
  logic [NSTAGE-1:0] valid;
  logic              drain_req;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic              pc_stall;
  logic              pc_redirect;
  logic [SW-1:0]     redir_src;
  logic              drain_busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output stall_req, flush_req, valid, drain_req,
    input  stall, flush, pc_stall, pc_redirect, redir_src, drain_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_req, flush_req, valid, drain_req,
    output stall, flush, pc_stall, pc_redirect, redir_src, drain_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush arbitration, deferred PC redirect,
// drain FSM for serialising instructions, and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned NSTAGE      = 5,
  parameter int unsigned DRAIN_STAGE = 1,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [SW-1:0]     pend_src_q, pend_src_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [NSTAGE-1:0] eff;
  logic [NSTAGE-1:0] raw_s;
  logic [NSTAGE-1:0] kill;
  logic [NSTAGE-1:0] bubble;
  logic [NSTAGE-1:0] flush;
  logic              hon_any;
  logic [SW-1:0]     win;
  logic              redirect;
  logic [SW-1:0]     src;
  logic              pc_stall;

  // Ascending scan: the last honored flush seen is the oldest, so it wins.
  always_comb begin : hazard
    eff = bus.stall_req;
    if (state_q == DRAIN) begin
      for (int unsigned i = 0; i <= DRAIN_STAGE; i++) eff[i] = 1'b1;
    end
    raw_s   = '0;
    kill    = '0;
    bubble  = '0;
    hon_any = 1'b0;
    win     = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      raw_s[i] = |(eff >> i);
      if (bus.flush_req[i] && !(|(eff >> (i + 1)))) begin
        hon_any = 1'b1;
        win     = SW'(i);
      end
    end
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      kill[i] = hon_any && (SW'(i) < win);
    end
    for (int unsigned i = 1; i < NSTAGE; i++) begin
      bubble[i] = raw_s[i-1] & ~raw_s[i];
    end
    flush    = kill | bubble;
    flush[0] = flush[0] | pend_q;
  end

  // A new redirect at least as old as the pending one replaces it.
  always_comb begin : redirect_sel
    redirect   = 1'b0;
    src        = '0;
    pend_d     = pend_q;
    pend_src_d = pend_src_q;
    if (hon_any && (!pend_q || win >= pend_src_q)) begin
      if (!bus.stall_req[0]) begin
        redirect = 1'b1;
        src      = win;
        pend_d   = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_src_d = win;
      end
    end else if (pend_q && !bus.stall_req[0]) begin
      redirect = 1'b1;
      src      = pend_src_q;
      pend_d   = 1'b0;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.drain_req && !raw_s[DRAIN_STAGE] && !kill[DRAIN_STAGE]) state_d = DRAIN;
      end
      DRAIN: begin
        if (kill[DRAIN_STAGE])                        state_d = RUN;
        else if ((bus.valid >> (DRAIN_STAGE + 1)) == '0) state_d = RELEASE;
      end
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign pc_stall = raw_s[0] & ~redirect;

  always_comb begin : counters
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      pend_src_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_src_q  <= pend_src_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall       = raw_s & ~flush;
  assign bus.flush       = flush;
  assign bus.pc_stall    = pc_stall;
  assign bus.pc_redirect = redirect;
  assign bus.redir_src   = src;
  assign bus.drain_busy  = (state_q != RUN);
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus random bench for pipe_hazard_ctrl against a behavioural model
// phrased in terms of the oldest stalling stage and the oldest honored flush.
module tb_pipe_hazard_ctrl;
  localparam int N  = 5;
  localparam int D  = 1;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pipe_hazard_ctrl_if #(.NSTAGE(N), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.NSTAGE(N), .DRAIN_STAGE(D), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: draining / releasing / pending redirect / counters.
  bit m_hold, m_rel, m_pend;
  int m_psrc, m_sc, m_fc;
  bit n_hold, n_rel, n_pend;
  int n_psrc, n_sc, n_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hold = 0; m_rel = 0; m_pend = 0; m_psrc = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_check();
    int os, win, src;
    bit redir, pcs, killd;
    logic [4:0] kmask, bmask, ef, es, smask;
    os = -1;
    for (int i = 0; i < N; i++)
      if (bus.stall_req[i] || (m_hold && i <= D)) os = i;
    win = -1;
    for (int k = 0; k < N; k++)
      if (bus.flush_req[k] && k >= os) win = k;
    kmask = (win > 0) ? 5'((1 << win) - 1) : 5'd0;
    bmask = (os >= 0 && os < N - 1) ? 5'(1 << (os + 1)) : 5'd0;
    ef    = kmask | bmask | {4'd0, m_pend};
    smask = 5'((1 << (os + 1)) - 1);
    es    = smask & ~ef;
    redir = 0; src = 0; n_pend = m_pend; n_psrc = m_psrc;
    if (win >= 0 && (!m_pend || win >= m_psrc)) begin
      if (!bus.stall_req[0]) begin redir = 1; src = win; n_pend = 0; end
      else begin n_pend = 1; n_psrc = win; end
    end else if (m_pend && !bus.stall_req[0]) begin
      redir = 1; src = m_psrc; n_pend = 0;
    end
    pcs = (os >= 0) && !redir;
    chk("stall",       32'(bus.stall),       32'(es));
    chk("flush",       32'(bus.flush),       32'(ef));
    chk("pc_stall",    32'(bus.pc_stall),    32'(pcs));
    chk("pc_redirect", 32'(bus.pc_redirect), 32'(redir));
    chk("redir_src",   32'(bus.redir_src),   32'(src));
    chk("drain_busy",  32'(bus.drain_busy),  32'(m_hold || m_rel));
    chk("stall_cnt",   32'(bus.stall_cnt),   32'(m_sc));
    chk("flush_cnt",   32'(bus.flush_cnt),   32'(m_fc));
    n_sc = (pcs && m_sc < CMAX) ? m_sc + 1 : m_sc;
    n_fc = (redir && m_fc < CMAX) ? m_fc + 1 : m_fc;
    killd = (win > D);
    n_hold = 0; n_rel = 0;
    if (m_hold) begin
      if (!killd) begin
        if ((bus.valid >> (D + 1)) == 0) n_rel = 1;
        else n_hold = 1;
      end
    end else if (!m_rel) begin
      n_hold = bus.drain_req && (os < D) && !killd;
    end
  endtask

  task automatic apply(input logic [4:0] sr, input logic [4:0] fr, input logic [4:0] vl, input logic dr);
    @(negedge clk);
    bus.stall_req = sr;
    bus.flush_req = fr;
    bus.valid     = vl;
    bus.drain_req = dr;
    #1;
    model_check();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (reset) model_clear();
    else begin
      m_hold = n_hold; m_rel = n_rel; m_pend = n_pend;
      m_psrc = n_psrc; m_sc = n_sc; m_fc = n_fc;
    end
  endtask

  // Called just after apply(): asserts reset between edges and checks the async clear.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("rst_stall_cnt", 32'(bus.stall_cnt),  32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt),  32'd0);
    chk("rst_busy",      32'(bus.drain_busy), 32'd0);
    @(posedge clk);
    model_clear();
    #3 reset = 1'b0;
  endtask

  initial begin
    bus.stall_req = '0;
    bus.flush_req = '0;
    bus.valid     = '0;
    bus.drain_req = 1'b0;
    model_clear();
    #1;
    chk("init_stall_cnt", 32'(bus.stall_cnt),  32'd0);
    chk("init_busy",      32'(bus.drain_busy), 32'd0);
    apply(5'b00000, 5'b00000, 5'b00000, 1'b0);
    clock_edge();
    #3 reset = 1'b0;

    // Stall in the middle of the pipe
    apply(5'b00100, 5'b00000, 5'b11111, 1'b0);
    chk("d_stall",    32'(bus.stall),    32'(5'b00111));
    chk("d_flush",    32'(bus.flush),    32'(5'b01000));
    chk("d_pc_stall", 32'(bus.pc_stall), 32'd1);
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b11111, 1'b0);
    chk("d_stall_cnt1", 32'(bus.stall_cnt), 32'd1);
    clock_edge();

    // Two flushes: the oldest wins
    apply(5'b00000, 5'b01010, 5'b11111, 1'b0);
    chk("d_flush_k3", 32'(bus.flush),       32'(5'b00111));
    chk("d_redir",    32'(bus.pc_redirect), 32'd1);
    chk("d_src3",     32'(bus.redir_src),   32'd3);
    clock_edge();

    // Redirect deferred while fetch is stalled
    apply(5'b00001, 5'b00100, 5'b11111, 1'b0);
    chk("d_pend_noredir", 32'(bus.pc_redirect), 32'd0);
    chk("d_pend_f0",      32'(bus.flush[0]),    32'd1);
    clock_edge();
    for (int c = 0; c < 2; c++) begin
      apply(5'b00001, 5'b00000, 5'b11111, 1'b0);
      chk("d_pend_hold", 32'(bus.pc_redirect), 32'd0);
      chk("d_pend_f0h",  32'(bus.flush[0]),    32'd1);
      clock_edge();
    end
    apply(5'b00000, 5'b00000, 5'b11111, 1'b0);
    chk("d_pend_redir", 32'(bus.pc_redirect), 32'd1);
    chk("d_pend_src",   32'(bus.redir_src),   32'd2);
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b11111, 1'b0);
    chk("d_pend_clr", 32'(bus.flush[0]), 32'd0);
    clock_edge();

    // Drain sequence
    apply(5'b00000, 5'b00000, 5'b11110, 1'b1);
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b11110, 1'b1);
    chk("d_drain_busy",  32'(bus.drain_busy), 32'd1);
    chk("d_drain_stall", 32'(bus.stall),      32'(5'b00011));
    chk("d_drain_flush", 32'(bus.flush),      32'(5'b00100));
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b00010, 1'b1);
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b00010, 1'b0);
    chk("d_release_busy",  32'(bus.drain_busy), 32'd1);
    chk("d_release_stall", 32'(bus.stall),      32'd0);
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b00010, 1'b0);
    chk("d_run_busy", 32'(bus.drain_busy), 32'd0);
    clock_edge();

    // Kill of the draining stage aborts the drain
    apply(5'b00000, 5'b00000, 5'b11110, 1'b1);
    clock_edge();
    apply(5'b00000, 5'b01000, 5'b11110, 1'b0);
    chk("d_abort_flush", 32'(bus.flush), 32'(5'b00111));
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b11110, 1'b0);
    chk("d_abort_busy", 32'(bus.drain_busy), 32'd0);
    clock_edge();

    // Counter saturation, then async clear
    for (int c = 0; c < 20; c++) begin
      apply(5'b00001, 5'b00000, 5'b11111, 1'b0);
      clock_edge();
    end
    apply(5'b00000, 5'b00000, 5'b11111, 1'b0);
    chk("d_sat", 32'(bus.stall_cnt), 32'(CMAX));
    reset_pulse();

    // Reset discards a pending redirect and a drain in progress
    apply(5'b00001, 5'b01000, 5'b11111, 1'b0);
    clock_edge();
    apply(5'b00001, 5'b00000, 5'b11111, 1'b0);
    reset_pulse();
    apply(5'b00000, 5'b00000, 5'b11111, 1'b0);
    chk("d_no_redir_after_rst", 32'(bus.pc_redirect), 32'd0);
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b11110, 1'b1);
    clock_edge();
    apply(5'b00000, 5'b00000, 5'b11110, 1'b0);
    reset_pulse();
    apply(5'b00000, 5'b00000, 5'b11110, 1'b0);
    chk("d_no_drain_after_rst", 32'(bus.drain_busy), 32'd0);
    clock_edge();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      logic [4:0] sr, fr, vl;
      logic dr;
      for (int b = 0; b < N; b++) begin
        sr[b] = ($urandom_range(0, 5) == 0);
        fr[b] = ($urandom_range(0, 7) == 0);
      end
      vl = 5'($urandom);
      dr = ($urandom_range(0, 3) == 0);
      apply(sr, fr, vl, dr);
      if ($urandom_range(0, 59) == 0) reset_pulse();
      else clock_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
